// File: rtl/ctrl_pkg.sv
// Shared control encodings for the pipeline control stages: branch funct3
// codes, result-select codes and a reserved-funct3 helper.
package ctrl_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // 010 and 011 have no branch meaning
    function automatic logic f3_reserved(input logic [2:0] funct3);
        return (funct3 == 3'b010) || (funct3 == 3'b011);
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition decode: funct3 plus ALU flags -> taken,
// and flags a real branch carrying a reserved funct3.
module branch_cond
    import ctrl_pkg::*;
(
    input  logic       valid,
    input  logic       branch,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = !zero;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = !lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    assign illegal = valid & branch & f3_reserved(funct3);

endmodule

// File: rtl/ctrl_exmem_stage.sv
// EX->MEM control pipeline register with one-shot PC redirect under stall.
// Optional branch statistics counters: define CTRL_EXMEM_BRANCH_STATS_EN.
module ctrl_exmem_stage
    import ctrl_pkg::*;
#(
    parameter int RESULT_SRC_W = 2,
    parameter int FUNCT_W      = 1,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_m,
    input  logic                    flush_m,
    input  logic                    valid_e,
    input  logic                    reg_write_e,
    input  logic                    mem_write_e,
    input  logic                    jump_e,
    input  logic                    branch_e,
    input  logic [RESULT_SRC_W-1:0] result_src_e,
    input  logic [FUNCT_W-1:0]      funct_e,
    input  logic [2:0]              funct3_e,
    input  logic                    zero_e,
    input  logic                    lt_e,
    input  logic                    ltu_e,
    output logic                    pc_src_e,
    output logic                    illegal_br_e,
    output logic                    valid_m,
    output logic                    reg_write_m,
    output logic                    mem_write_m,
    output logic [RESULT_SRC_W-1:0] result_src_m,
`ifdef CTRL_EXMEM_BRANCH_STATS_EN
    output logic [FUNCT_W-1:0]      funct_m,
    output logic [CNT_W-1:0]        br_cnt,
    output logic [CNT_W-1:0]        br_taken_cnt
`else
    output logic [FUNCT_W-1:0]      funct_m
`endif
);

    logic taken;
    logic redirect_done;

    branch_cond u_branch_cond (
        .valid   (valid_e),
        .branch  (branch_e),
        .funct3  (funct3_e),
        .zero    (zero_e),
        .lt      (lt_e),
        .ltu     (ltu_e),
        .taken   (taken),
        .illegal (illegal_br_e)
    );

    assign pc_src_e = valid_e & (jump_e | (branch_e & taken)) & !redirect_done;

    // Remembers that the held E instruction already redirected the PC, so a
    // long stall yields a single redirect pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            redirect_done <= 1'b0;
        else if (!stall_m)
            redirect_done <= 1'b0;
        else if (pc_src_e)
            redirect_done <= 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_m      <= 1'b0;
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= '0;
            funct_m      <= '0;
        end else if (flush_m) begin
            valid_m      <= 1'b0;
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= RESULT_SRC_W'(RES_ALU);
            funct_m      <= '0;
        end else if (!stall_m) begin
            // write enables are qualified so a bubble can never write
            valid_m      <= valid_e;
            reg_write_m  <= reg_write_e & valid_e;
            mem_write_m  <= mem_write_e & valid_e;
            result_src_m <= result_src_e;
            funct_m      <= funct_e;
        end
    end

`ifdef CTRL_EXMEM_BRANCH_STATS_EN
    logic br_adv;
    assign br_adv = valid_e & branch_e & !stall_m & !flush_m;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_cnt       <= '0;
            br_taken_cnt <= '0;
        end else if (br_adv) begin
            if (br_cnt != '1)
                br_cnt <= br_cnt + CNT_W'(1);
            if (taken && (br_taken_cnt != '1))
                br_taken_cnt <= br_taken_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_exmem_stage.sv
// Scoreboard bench for ctrl_exmem_stage: directed scenarios plus random
// traffic checked against a behavioural model of the stage.
module tb_ctrl_exmem_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stall_m = 0, flush_m = 0, valid_e = 0;
    logic       reg_write_e = 0, mem_write_e = 0, jump_e = 0, branch_e = 0;
    logic [1:0] result_src_e = 0;
    logic [0:0] funct_e = 0;
    logic [2:0] funct3_e = 0;
    logic       zero_e = 0, lt_e = 0, ltu_e = 0;
    logic       pc_src_e, illegal_br_e, valid_m, reg_write_m, mem_write_m;
    logic [1:0] result_src_m;
    logic [0:0] funct_m;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

`ifdef CTRL_EXMEM_BRANCH_STATS_EN
    logic [15:0] br_cnt, br_taken_cnt;
    logic [1:0]  br_cnt_s, br_taken_cnt_s;
    logic        s_pc, s_il, s_v, s_rw, s_mw;
    logic [1:0]  s_rs;
    logic [0:0]  s_f;
`endif

    ctrl_exmem_stage #(.RESULT_SRC_W(2), .FUNCT_W(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall_m(stall_m), .flush_m(flush_m),
        .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .jump_e(jump_e), .branch_e(branch_e), .result_src_e(result_src_e),
        .funct_e(funct_e), .funct3_e(funct3_e), .zero_e(zero_e), .lt_e(lt_e),
        .ltu_e(ltu_e), .pc_src_e(pc_src_e), .illegal_br_e(illegal_br_e),
        .valid_m(valid_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
        .result_src_m(result_src_m),
`ifdef CTRL_EXMEM_BRANCH_STATS_EN
        .funct_m(funct_m), .br_cnt(br_cnt), .br_taken_cnt(br_taken_cnt)
`else
        .funct_m(funct_m)
`endif
    );

`ifdef CTRL_EXMEM_BRANCH_STATS_EN
    // narrow-counter instance to exercise saturation
    ctrl_exmem_stage #(.RESULT_SRC_W(2), .FUNCT_W(1), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .stall_m(stall_m), .flush_m(flush_m),
        .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .jump_e(jump_e), .branch_e(branch_e), .result_src_e(result_src_e),
        .funct_e(funct_e), .funct3_e(funct3_e), .zero_e(zero_e), .lt_e(lt_e),
        .ltu_e(ltu_e), .pc_src_e(s_pc), .illegal_br_e(s_il),
        .valid_m(s_v), .reg_write_m(s_rw), .mem_write_m(s_mw),
        .result_src_m(s_rs), .funct_m(s_f), .br_cnt(br_cnt_s),
        .br_taken_cnt(br_taken_cnt_s)
    );
`endif

    typedef struct {
        logic       rst, stall, flush, valid, rw, mw, j, br;
        logic [1:0] rs;
        logic [0:0] f;
        logic [2:0] f3;
        logic       z, lt, ltu;
    } stim_t;

    typedef struct {
        logic pc, il;
    } cexp_t;

    typedef struct {
        logic       v, rw, mw;
        logic [1:0] rs;
        logic [0:0] f;
        int         nb, nt;
    } mexp_t;

    cexp_t cq[$];
    mexp_t mq[$];

    // reference model state
    mexp_t mdl = '{default: 0};
    logic  mdl_redirected = 1'b0;

    function automatic logic ref_taken(input logic [2:0] f3, input logic z, lt, ltu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic drive(input stim_t s);
        logic  tk;
        cexp_t c;
        @(negedge clk);
        reset = s.rst; stall_m = s.stall; flush_m = s.flush; valid_e = s.valid;
        reg_write_e = s.rw; mem_write_e = s.mw; jump_e = s.j; branch_e = s.br;
        result_src_e = s.rs; funct_e = s.f; funct3_e = s.f3;
        zero_e = s.z; lt_e = s.lt; ltu_e = s.ltu;
        #1;
        if (s.rst) begin
            mdl = '{default: 0};
            mdl_redirected = 1'b0;
            check("rst_async_valid", valid_m, 0);
            check("rst_async_wr", {reg_write_m, mem_write_m, result_src_m, funct_m}, 0);
        end
        tk = ref_taken(s.f3, s.z, s.lt, s.ltu);
        c.pc = s.valid && (s.j || (s.br && tk)) && !mdl_redirected;
        c.il = s.valid && s.br && (s.f3 == 3'd2 || s.f3 == 3'd3);
        cq.push_back(c);
        if (!s.rst) begin
            if (!s.stall)  mdl_redirected = 1'b0;
            else if (c.pc) mdl_redirected = 1'b1;
            if (s.valid && s.br && !s.stall && !s.flush) begin
                mdl.nb++;
                if (tk) mdl.nt++;
            end
            if (s.flush) begin
                mdl.v = 0; mdl.rw = 0; mdl.mw = 0; mdl.rs = 0; mdl.f = 0;
            end else if (!s.stall) begin
                mdl.v = s.valid; mdl.rw = s.rw && s.valid; mdl.mw = s.mw && s.valid;
                mdl.rs = s.rs; mdl.f = s.f;
            end
        end
        mq.push_back(mdl);
    endtask

    // comparison monitors, decoupled from the driver
    initial forever begin
        cexp_t c;
        @(negedge clk); #2;
        if (cq.size() != 0) begin
            c = cq.pop_front();
            check("pc_src_e", pc_src_e, c.pc);
            check("illegal_br_e", illegal_br_e, c.il);
        end
    end

    initial forever begin
        mexp_t m;
        @(posedge clk); #1;
        if (mq.size() != 0) begin
            m = mq.pop_front();
            check("m_ctrl", {valid_m, reg_write_m, mem_write_m},
                  {m.v, m.rw, m.mw});
            check("m_side", {result_src_m, funct_m}, {m.rs, m.f});
            n_tests++;
            if (!valid_m && (reg_write_m || mem_write_m)) begin
                n_fail++;
                $display("FAIL wr_without_valid: rw=%0b mw=%0b", reg_write_m, mem_write_m);
            end
`ifdef CTRL_EXMEM_BRANCH_STATS_EN
            check("br_cnt", br_cnt, sat(m.nb, 16));
            check("br_taken_cnt", br_taken_cnt, sat(m.nt, 16));
            check("br_cnt_sat", br_cnt_s, sat(m.nb, 2));
            check("br_taken_cnt_sat", br_taken_cnt_s, sat(m.nt, 2));
`endif
        end
    end

    function automatic stim_t br(input logic [2:0] f3, input logic z, lt, ltu);
        stim_t s;
        s = idle();
        s.valid = 1; s.br = 1; s.f3 = f3; s.z = z; s.lt = lt; s.ltu = ltu;
        return s;
    endfunction

    initial begin
        stim_t s;
        s = idle(); s.rst = 1;
        drive(s);
        drive(s);
        check("reset_valid_m", valid_m, 0);

        // branch decode
        drive(br(3'b100, 0, 1, 0));
        check("dec_blt", pc_src_e, 1);
        drive(br(3'b101, 0, 1, 0));
        check("dec_bge", pc_src_e, 0);
        drive(br(3'b010, 0, 1, 0));
        check("dec_rsv_pc", pc_src_e, 0);
        check("dec_rsv_ill", illegal_br_e, 1);

        // stalled jump: one pulse, then re-arms after stall drops
        s = idle(); s.valid = 1; s.j = 1; s.stall = 1;
        drive(s); check("sj_c1", pc_src_e, 1);
        drive(s); check("sj_c2", pc_src_e, 0);
        drive(s); check("sj_c3", pc_src_e, 0);
        s.stall = 0;
        drive(s); check("sj_release", pc_src_e, 0);
        drive(s); check("sj_rearm", pc_src_e, 1);

        // hold then flush during stall
        s = idle(); s.valid = 1; s.mw = 1; s.rs = 2'b01;
        drive(s);
        s = idle(); s.stall = 1;
        drive(s);
        s.flush = 1;
        drive(s);
        check("hold_keeps", {valid_m, mem_write_m, result_src_m}, {1'b1, 1'b1, 2'b01});
        drive(idle());
        check("flush_over_stall", {valid_m, mem_write_m}, 0);

        // invalid instruction cannot write or redirect
        s = idle(); s.rw = 1; s.mw = 1; s.j = 1;
        drive(s); check("inv_pc", pc_src_e, 0);
        drive(idle()); check("inv_wr", {reg_write_m, mem_write_m}, 0);

        // reset mid-stream and during a stalled redirect
        s = idle(); s.valid = 1; s.rw = 1; s.j = 1; s.stall = 1;
        drive(s);
        s.stall = 0; drive(s);
        s.stall = 1; drive(s);
        s.rst = 1; drive(s);
        check("rst_clears_redirect", pc_src_e, 1);
        s = idle(); s.valid = 1;
        drive(s);
        drive(idle());
        check("post_rst_valid", valid_m, 1);

`ifdef CTRL_EXMEM_BRANCH_STATS_EN
        s = idle(); s.rst = 1; drive(s);
        drive(br(3'b000, 1, 0, 0));
        drive(br(3'b001, 1, 0, 0));
        s = br(3'b000, 1, 0, 0); s.stall = 1; drive(s);
        drive(br(3'b100, 0, 1, 0));
        drive(br(3'b101, 0, 1, 0));
        drive(br(3'b110, 0, 0, 1));
        drive(idle());
        check("stats_br5", br_cnt, 5);
        check("stats_taken3", br_taken_cnt, 3);
        for (int i = 0; i < 4; i++) drive(br(3'b000, 0, 0, 0));
        drive(idle());
        check("stats_sat", br_cnt_s, 3);
        check("stats_wide9", br_cnt, 9);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            s.rst   = ($urandom_range(0, 99) == 0);
            s.stall = ($urandom_range(0, 3) == 0);
            s.flush = ($urandom_range(0, 9) == 0);
            s.valid = ($urandom_range(0, 4) != 0);
            s.rw = 1'($urandom); s.mw = 1'($urandom);
            s.j  = ($urandom_range(0, 5) == 0);
            s.br = 1'($urandom);
            s.rs = 2'($urandom); s.f = 1'($urandom); s.f3 = 3'($urandom);
            s.z = 1'($urandom); s.lt = 1'($urandom); s.ltu = 1'($urandom);
            drive(s);
        end
        drive(idle());
        drive(idle());
        @(posedge clk); #3;
        if (cq.size() != 0 || mq.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: %0d/%0d expectations left", cq.size(), mq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
